instr_fetch: RTL

Instruction fetch stage for the MIPS32 pipeline. It holds the program counter, issues one-at-a-time requests to instruction memory, and presents each fetched 32-bit word (IR) to the decoder over a valid/ready handshake. It is redirected by branch/jump resolution and stops permanently after delivering an HLT instruction.

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 23 ++
 rtl/instr_fetch.sv | 83 ++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared ISA field positions, HLT opcode and fetch FSM encoding
package instr_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam logic [5:0] OPC_HLT = 6'b111111;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;
  function automatic logic is_hlt(input logic [5:0] opc);
    return opc == OPC_HLT;
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory bus, decoder IR handshake and redirect/halt signals
interface instr_fetch_if #(parameter int PC_W = 32);
  import instr_fetch_pkg::*;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    ir_pc;
  logic               ir_valid;
  logic               ir_ready;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;
  modport master (
    output imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
    input  imem_rdata, imem_rvalid, ir_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
    output imem_rdata, imem_rvalid, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS32 fetch stage with one request in flight, redirect drop and sticky halt
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          PC_W     = 32
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);
  fetch_state_t       state, state_n;
  logic [PC_W-1:0]    pc, pc_n, tgt, tgt_n, ir_pc_n;
  logic [INSTR_W-1:0] ir_n;
  logic               drop, drop_n;
  assign bus.imem_addr = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= PC_W'(RESET_PC);
      tgt          <= '0;
      drop         <= 1'b0;
      bus.ir       <= '0;
      bus.ir_pc    <= '0;
      bus.imem_req <= 1'b0;
      bus.ir_valid <= 1'b0;
      bus.halted   <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      tgt          <= tgt_n;
      drop         <= drop_n;
      bus.ir       <= ir_n;
      bus.ir_pc    <= ir_pc_n;
      bus.imem_req <= state_n == S_REQ;
      bus.ir_valid <= state_n == S_HOLD;
      bus.halted   <= state_n == S_HALT;
    end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    drop_n  = drop;
    ir_n    = bus.ir;
    ir_pc_n = bus.ir_pc;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        pc_n    = bus.redirect ? bus.redirect_pc : pc;
      end
      S_REQ: begin
        state_n = S_WAIT;
        if (bus.redirect) begin
          pc_n   = bus.redirect_pc;
          tgt_n  = bus.redirect_pc;
          drop_n = 1'b1;
        end
      end
      S_WAIT:
        if (bus.imem_rvalid && (bus.redirect || drop)) begin
          state_n = S_REQ;
          pc_n    = bus.redirect ? bus.redirect_pc : tgt;
          drop_n  = 1'b0;
        end else if (bus.imem_rvalid) begin
          state_n = S_HOLD;
          ir_n    = bus.imem_rdata;
          ir_pc_n = pc;
        end else if (bus.redirect) begin
          tgt_n  = bus.redirect_pc;
          drop_n = 1'b1;
        end
      S_HOLD:
        if (bus.ir_ready && is_hlt(bus.ir[OPC_HI:OPC_LO]))
          state_n = S_HALT;
        else if (bus.redirect || bus.ir_ready) begin
          state_n = S_REQ;
          pc_n    = bus.redirect ? bus.redirect_pc : pc + 1'b1;
        end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end
endmodule
